ingress_frame_arbiter: RTL and testbench

INGRESS_FRAME_ARBITER -- requirements
Module: ingress_frame_arbiter

---
 rtl/ingress_frame_arbiter_if.sv | 34 +++
 rtl/ingress_frame_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ingress_frame_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_frame_arbiter_if.sv
// ingress_frame_arbiter_if
//   Bundles the NUM_PORTS ingress AXI-Stream requesters and the merged
//   egress stream of the ingress frame arbiter.
//   master : arbiter view. It drives s_tready and the merged m_* stream, and
//            samples s_tvalid/s_tdata/s_tlast and m_tready.
//   slave  : environment view (requesters plus frame parser), the mirror image.
//   s_tdata is flat: port i occupies bits [i*DATA_W +: DATA_W].
interface ingress_frame_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        s_tvalid;
  logic [NUM_PORTS-1:0]        s_tready;
  logic [NUM_PORTS*DATA_W-1:0] s_tdata;
  logic [NUM_PORTS-1:0]        s_tlast;
  logic                        m_tvalid;
  logic                        m_tready;
  logic [DATA_W-1:0]           m_tdata;
  logic                        m_tlast;
  logic [PW-1:0]               m_tid;
  logic                        m_abort;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_abort
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_abort
  );
endinterface

// File: rtl/ingress_frame_arbiter.sv
// ingress_frame_arbiter
//   Round-robin, frame-granular arbiter merging NUM_PORTS AXI-Stream
//   requesters into one stream toward the frame parser. A grant is taken in
//   IDLE (one bubble cycle per frame) and held until the granted port's
//   tlast is accepted; the datapath in BUSY is purely combinational.
//
//   Optional feature, macro INGRESS_ARB_WATCHDOG_EN: stall watchdog. After
//   STALL_LIMIT consecutive cycles with the granted port idle mid-frame, a
//   synthetic abort beat (tdata 0, tlast 1, m_abort 1) is emitted and the
//   rest of the stalled frame is sunk up to its tlast.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : ingress_frame_arbiter_if.master (s_* requesters, m_* merged)
//   busy      : a grant is held (state != IDLE)
//   stall_err : one-cycle pulse in the first ABORT cycle (0 without watchdog)
module ingress_frame_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 64,
  parameter int STALL_LIMIT = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ingress_frame_arbiter_if.master bus,
  output logic                    busy,
  output logic                    stall_err
);
  localparam int PW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_np_chk
    $error("ingress_frame_arbiter: NUM_PORTS must be 2..8");
  end
  if (STALL_LIMIT < 2 || STALL_LIMIT > 65535) begin : g_sl_chk
    $error("ingress_frame_arbiter: STALL_LIMIT must be 2..65535");
  end

`ifdef INGRESS_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;
`else
  typedef enum logic {IDLE, BUSY} state_t;
`endif

  state_t                state, state_nx;
  logic [PW-1:0]         gnt, gnt_nx, rr_ptr, rr_nx, pick, gnt_inc;
  logic [PW-1:0]         cand [NUM_PORTS];
  logic [NUM_PORTS-1:0]  s_rdy;
  logic                  m_vld, m_lst, m_ab;
  logic [DATA_W-1:0]     m_dat;
  logic [PW-1:0]         m_id;
`ifdef INGRESS_ARB_WATCHDOG_EN
  logic [15:0]           stall_cnt, cnt_nx;
  logic                  err_q, err_nx;
`endif

  // cand[k]: port visited k-th when searching cyclically from rr_ptr
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cand
    assign cand[k] = PW'((int'(rr_ptr) + k) % NUM_PORTS);
  end

  // Descending scan so the nearest requester (smallest k) wins
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.s_tvalid[cand[k]]) pick = cand[k];
    end
  end

  assign gnt_inc = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
`ifdef INGRESS_ARB_WATCHDOG_EN
      stall_cnt <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      rr_ptr    <= rr_nx;
`ifdef INGRESS_ARB_WATCHDOG_EN
      stall_cnt <= cnt_nx;
      err_q     <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr_ptr;
    s_rdy    = '0;
    m_vld    = 1'b0;
    m_dat    = '0;
    m_lst    = 1'b0;
    m_ab     = 1'b0;
    m_id     = '0;
`ifdef INGRESS_ARB_WATCHDOG_EN
    cnt_nx   = '0;
    err_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|bus.s_tvalid) begin
          gnt_nx   = pick;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        m_id       = gnt;
        m_vld      = bus.s_tvalid[gnt];
        m_dat      = bus.s_tdata[int'(gnt)*DATA_W +: DATA_W];
        m_lst      = bus.s_tlast[gnt];
        s_rdy[gnt] = bus.m_tready;
        if (m_vld && bus.m_tready && m_lst) begin
          state_nx = IDLE;
          rr_nx    = gnt_inc;
        end
`ifdef INGRESS_ARB_WATCHDOG_EN
        // cnt_nx stays 0 on any cycle the granted port is valid
        if (!bus.s_tvalid[gnt]) begin
          if (stall_cnt == 16'(STALL_LIMIT - 1)) begin
            state_nx = ABORT;
            err_nx   = 1'b1;
          end else begin
            cnt_nx = stall_cnt + 16'd1;
          end
        end
`endif
      end
`ifdef INGRESS_ARB_WATCHDOG_EN
      ABORT: begin
        m_id  = gnt;
        m_vld = 1'b1;
        m_lst = 1'b1;
        m_ab  = 1'b1;
        if (bus.m_tready) state_nx = DRAIN;
      end
      DRAIN: begin
        // sink the remainder of the stalled frame, nothing goes downstream
        m_id       = gnt;
        s_rdy[gnt] = 1'b1;
        if (bus.s_tvalid[gnt] && bus.s_tlast[gnt]) begin
          state_nx = IDLE;
          rr_nx    = gnt_inc;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign bus.s_tready = s_rdy;
  assign bus.m_tvalid = m_vld;
  assign bus.m_tdata  = m_dat;
  assign bus.m_tlast  = m_lst;
  assign bus.m_tid    = m_id;
  assign busy         = (state != IDLE);
`ifdef INGRESS_ARB_WATCHDOG_EN
  assign bus.m_abort  = m_ab;
  assign stall_err    = err_q;
`else
  assign bus.m_abort  = 1'b0;
  assign stall_err    = 1'b0;
`endif
endmodule

// File: tb/tb_ingress_frame_arbiter.sv
// tb_ingress_frame_arbiter
//   Directed frames per port; expected merged beats queued at issue time and
//   compared by a monitor as the arbiter delivers them.
module tb_ingress_frame_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int SL = 4;
  localparam int PW = $clog2(NP);

  logic clk = 1'b0;
  logic rst_n;
  logic busy, stall_err;
  always #5 clk = ~clk;

  ingress_frame_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  ingress_frame_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .STALL_LIMIT(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .stall_err (stall_err)
  );

  typedef struct packed { logic v; logic l; logic [DW-1:0] d; } beat_t;
  typedef struct { logic [PW-1:0] tid; logic [DW-1:0] d; logic l; logic ab; int gap; } exp_t;
  typedef struct { string nm; logic [63:0] act; logic [63:0] exp; } chk_t;

  beat_t         src_q [NP][$];
  exp_t          exp_q [$];
  chk_t          chk_q [$];
  logic          rdy_q [$];
  logic [NP-1:0] fire;
  int            n_chk = 0, n_pass = 0, n_stall = 0, cyc = 0, last_cyc = 0;
  exp_t          mon_e;
  chk_t          mon_c;

  function automatic logic [DW-1:0] mk(input int p, input int f, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | (64'(f) << 8) | 64'(b);
  endfunction

  // only the monitor calls this
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic probe(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{nm: nm, act: act, exp: exp});
  endtask

  // nb beats; gap_len idle cycles inserted after beat index gap_after
  task automatic send(input int p, input int f, input int nb, input int gap_after, input int gap_len);
    for (int b = 0; b < nb; b++) begin
      src_q[p].push_back('{v: 1'b1, l: (b == nb - 1), d: mk(p, f, b)});
      if (b == gap_after)
        for (int g = 0; g < gap_len; g++) src_q[p].push_back('{v: 1'b0, l: 1'b0, d: '0});
    end
  endtask

  // gap: required cycle distance from the previous accepted beat, 0 = don't care
  task automatic expect_frame(input int p, input int f, input int nb, input int g_first, input int g_rest);
    for (int b = 0; b < nb; b++)
      exp_q.push_back('{tid: PW'(p), d: mk(p, f, b), l: (b == nb - 1), ab: 1'b0,
                        gap: (b == 0) ? g_first : g_rest});
  endtask

  task automatic settle(input string nm, input bit src_too);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #1;
      done = (exp_q.size() == 0);
      if (src_too) for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) done = 1'b0;
    end
    probe({nm, "_drained"}, 64'(done), 64'd1);
  endtask

  // source driver: beats advance on handshake, idle entries last one cycle
  initial begin
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0; bus.m_tready = 1'b1;
    forever begin
      @(negedge clk);
      fire = bus.s_tvalid & bus.s_tready;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++)
        if (src_q[p].size() > 0 && (!src_q[p][0].v || fire[p])) src_q[p].delete(0);
      bus.m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0 && src_q[p][0].v) begin
          bus.s_tvalid[p] = 1'b1;
          bus.s_tlast[p]  = src_q[p][0].l;
          bus.s_tdata[p*DW +: DW] = src_q[p][0].d;
        end else begin
          bus.s_tvalid[p] = 1'b0;
          bus.s_tlast[p]  = 1'b0;
          bus.s_tdata[p*DW +: DW] = '0;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      while (chk_q.size() > 0) begin
        mon_c = chk_q.pop_front();
        chk(mon_c.nm, mon_c.act, mon_c.exp);
      end
      if (rst_n === 1'b1) begin
        if (stall_err) n_stall++;
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got tid=%0d data=%0h, want no beat", bus.m_tid, bus.m_tdata);
          end else begin
            mon_e = exp_q.pop_front();
            chk("m_tid", 64'(bus.m_tid), 64'(mon_e.tid));
            chk("m_tdata", bus.m_tdata, mon_e.d);
            chk("m_tlast", 64'(bus.m_tlast), 64'(mon_e.l));
            chk("m_abort", 64'(bus.m_abort), 64'(mon_e.ab));
            if (mon_e.gap != 0) chk("beat_gap", 64'(cyc - last_cyc), 64'(mon_e.gap));
          end
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    // all four ports request while held in reset; outputs must stay quiet
    for (int p = 0; p < NP; p++) send(p, 1, 3, -1, 0);
    expect_frame(0, 1, 3, 0, 1);
    for (int p = 1; p < NP; p++) expect_frame(p, 1, 3, 2, 1);
    repeat (3) @(posedge clk);
    #2;
    probe("rst_busy", 64'(busy), 64'd0);
    probe("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    probe("rst_s_tready", 64'(bus.s_tready), 64'd0);
    probe("rst_m_tid", 64'(bus.m_tid), 64'd0);
    probe("rst_m_tdata", bus.m_tdata, 64'd0);
    probe("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
    probe("rst_m_abort", 64'(bus.m_abort), 64'd0);
    probe("rst_stall_err", 64'(stall_err), 64'd0);
    rst_n = 1'b1;
    settle("rr_four_ports", 1'b1);
    repeat (2) @(posedge clk);
    #2;
    probe("idle_busy", 64'(busy), 64'd0);
    probe("idle_m_tid", 64'(bus.m_tid), 64'd0);

    // port 2 back-to-back frames while port 3 requests: 2,3,2
    send(2, 2, 2, -1, 0);
    send(2, 3, 2, -1, 0);
    send(3, 2, 2, -1, 0);
    expect_frame(2, 2, 2, 0, 0);
    expect_frame(3, 2, 2, 0, 0);
    expect_frame(2, 3, 2, 0, 0);
    settle("alternate_2_3", 1'b1);
    repeat (2) @(posedge clk);
    #2;

    // backpressured 4-beat port-1 frame; port 0 arrives after the grant
    send(1, 4, 4, -1, 0);
    for (int i = 0; i < 12; i++) rdy_q.push_back(i % 2 == 0);
    expect_frame(1, 4, 4, 0, 0);
    expect_frame(0, 4, 2, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    send(0, 4, 2, -1, 0);
    @(posedge clk); #2;
    probe("hold_busy", 64'(busy), 64'd1);
    probe("hold_m_tid", 64'(bus.m_tid), 64'd1);
    settle("backpressure", 1'b1);
    repeat (2) @(posedge clk);
    #2;

    // reset during beat 2 of a port-3 frame
    send(3, 5, 4, -1, 0);
    expect_frame(3, 5, 2, 0, 0);
    exp_q[1].l = 1'b0;
    settle("pre_reset_beats", 1'b0);
    @(posedge clk); #2;
    probe("beat2_m_tvalid", 64'(bus.m_tvalid), 64'd1);
    probe("beat2_m_tdata", bus.m_tdata, mk(3, 5, 2));
    rst_n = 1'b0;
    #1;
    probe("midrst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    probe("midrst_busy", 64'(busy), 64'd0);
    probe("midrst_m_tid", 64'(bus.m_tid), 64'd0);
    probe("midrst_s_tready", 64'(bus.s_tready), 64'd0);
    for (int p = 0; p < NP; p++) src_q[p].delete();
    @(posedge clk); #2;
    send(2, 6, 1, -1, 0);
    send(0, 6, 1, -1, 0);
    expect_frame(0, 6, 1, 0, 0);
    expect_frame(2, 6, 1, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    settle("post_reset", 1'b1);
    repeat (2) @(posedge clk);
    #2;

`ifdef INGRESS_ARB_WATCHDOG_EN
    // port 0 stalls STALL_LIMIT cycles after its first beat
    send(0, 7, 3, 0, SL);
    send(1, 7, 2, -1, 0);
    exp_q.push_back('{tid: PW'(0), d: mk(0, 7, 0), l: 1'b0, ab: 1'b0, gap: 0});
    exp_q.push_back('{tid: PW'(0), d: '0, l: 1'b1, ab: 1'b1, gap: 0});
    expect_frame(1, 7, 2, 0, 0);
    settle("watchdog_abort", 1'b1);
    repeat (2) @(posedge clk);
    #2;
    probe("stall_err_pulses", 64'(n_stall), 64'd1);
    // one cycle short of the limit: normal completion
    send(2, 8, 2, 0, SL - 1);
    expect_frame(2, 8, 2, 0, 0);
    settle("watchdog_near_limit", 1'b1);
    repeat (2) @(posedge clk);
    #2;
    probe("stall_err_pulses_after", 64'(n_stall), 64'd1);
`else
    // without the watchdog a long stall never aborts
    send(0, 7, 2, 0, SL + 2);
    expect_frame(0, 7, 2, 0, 0);
    settle("long_stall", 1'b1);
    repeat (2) @(posedge clk);
    #2;
    probe("stall_err_pulses", 64'(n_stall), 64'd0);
`endif

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
